// File: rtl/msr_xfer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msr_xfer_arbiter
//  Purpose  : Multi-channel event timestamp capture with a round-robin
//             arbiter that hands one captured word per host request over a
//             slow GPIO-style req/rdy handshake.
//  Options  : MSR_OVERRUN_FLAG_EN adds per-channel overrun tracking and the
//             msr_ovr output (default build: feature absent).
//  Revision : 1.0  initial release
// ============================================================================
module msr_xfer_arbiter #(
  parameter int NCH = 4,
  parameter int TW  = 24,
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TW-1:0]  timer_val,
  input  logic [NCH-1:0] evt,
  input  logic           data_req,
  output logic           data_rdy,
  output logic [TW-1:0]  msr_data,
  output logic [CW-1:0]  msr_ch,
  output logic           msr_valid,
`ifdef MSR_OVERRUN_FLAG_EN
  output logic           msr_ovr,
`endif
  output logic [NCH-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NCH-1:0]  r_evt_s1, r_evt_s2, r_evt_s3;
  logic            r_req_s1, r_req_s2, r_req_s3;
  logic [1:0]      r_fill;
  logic            r_req_armed;
  logic [NCH-1:0]  r_pend;
  logic [TW-1:0]   r_hold [NCH];
  logic [CW-1:0]   r_last;
  logic            r_data_rdy;
  logic [TW-1:0]   r_msr_data;
  logic [CW-1:0]   r_msr_ch;
  logic            r_msr_valid;
`ifdef MSR_OVERRUN_FLAG_EN
  logic [NCH-1:0]  r_ovr;
  logic            r_msr_ovr;
`endif

  logic [NCH-1:0]  w_evt_rise;
  logic            w_req_rise;
  logic            w_gnt_vld;
  logic [CW-1:0]   w_gnt_idx;
  logic [CW-1:0]   w_cand;
  logic            w_fire;

  // Wrap an offset from the last grant back into the channel range.
  function automatic logic [CW-1:0] f_wrap(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return s[CW-1:0];
  endfunction

  // Two-flop synchronizers plus one edge-detect stage; the request path only
  // arms once a genuine low has been observed after reset, so a request held
  // high across reset release cannot start a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_s1    <= '0;
      r_evt_s2    <= '0;
      r_evt_s3    <= '0;
      r_req_s1    <= 1'b0;
      r_req_s2    <= 1'b0;
      r_req_s3    <= 1'b0;
      r_fill      <= 2'd0;
      r_req_armed <= 1'b0;
    end else begin
      r_evt_s1 <= evt;
      r_evt_s2 <= r_evt_s1;
      r_evt_s3 <= r_evt_s2;
      r_req_s1 <= data_req;
      r_req_s2 <= r_req_s1;
      r_req_s3 <= r_req_s2;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if ((r_fill == 2'd2) && !r_req_s2) r_req_armed <= 1'b1;
    end
  end

  assign w_evt_rise = r_evt_s2 & ~r_evt_s3;
  assign w_req_rise = r_req_s2 & ~r_req_s3 & r_req_armed;
  assign w_fire     = (r_state == S_IDLE) && w_req_rise && w_gnt_vld;

  // Round-robin pick: scan downward so the channel right after the last
  // grant is written last and therefore has the highest priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_cand = f_wrap(r_last, k);
      if (r_pend[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Per-channel capture: first capture wins while pending; a capture on the
  // channel being granted this cycle refills it instead of being lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
`ifdef MSR_OVERRUN_FLAG_EN
      r_ovr  <= '0;
`endif
      for (int i = 0; i < NCH; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_fire && (w_gnt_idx == CW'(i))) begin
          r_pend[i] <= w_evt_rise[i];
          if (w_evt_rise[i]) r_hold[i] <= timer_val;
`ifdef MSR_OVERRUN_FLAG_EN
          r_ovr[i] <= 1'b0;
`endif
        end else if (w_evt_rise[i]) begin
          if (!r_pend[i]) begin
            r_hold[i] <= timer_val;
            r_pend[i] <= 1'b1;
          end
`ifdef MSR_OVERRUN_FLAG_EN
          else r_ovr[i] <= 1'b1;
`endif
        end
      end
    end
  end

  // Handshake FSM; the output word only changes on the IDLE->SETTLE step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data_rdy  <= 1'b0;
      r_msr_data  <= '0;
      r_msr_ch    <= '0;
      r_msr_valid <= 1'b0;
      r_last      <= CW'(NCH - 1);
`ifdef MSR_OVERRUN_FLAG_EN
      r_msr_ovr   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_rise) begin
            if (w_gnt_vld) begin
              r_msr_data  <= r_hold[w_gnt_idx];
              r_msr_ch    <= w_gnt_idx;
              r_msr_valid <= 1'b1;
              r_last      <= w_gnt_idx;
`ifdef MSR_OVERRUN_FLAG_EN
              r_msr_ovr   <= r_ovr[w_gnt_idx];
`endif
            end else begin
              r_msr_valid <= 1'b0;
`ifdef MSR_OVERRUN_FLAG_EN
              r_msr_ovr   <= 1'b0;
`endif
            end
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_req_s2) begin
            r_data_rdy <= 1'b1;
            r_state    <= S_READY;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_READY: begin
          if (!r_req_s2) begin
            r_data_rdy <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_rdy  = r_data_rdy;
  assign msr_data  = r_msr_data;
  assign msr_ch    = r_msr_ch;
  assign msr_valid = r_msr_valid;
  assign pending   = r_pend;
`ifdef MSR_OVERRUN_FLAG_EN
  assign msr_ovr   = r_msr_ovr;
`endif

endmodule
`default_nettype wire
